// File: rtl/cnt16_seq_pkg.sv
// Shared encodings and defaults for the count16 command sequencer.
package cnt16_seq_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 4;
  localparam int unsigned CNT_TIMEOUT_DEF = 20;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_RUN  = 2'd1,
    OP_HOLD = 2'd2,
    OP_OE   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

endpackage

// File: rtl/cnt16_seq_if.sv
// Command channel into the sequencer: valid/ready with opcode and data.
interface cnt16_seq_if
  import cnt16_seq_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, output cmd_ready);

endinterface

// File: rtl/cnt16_seq_timer.sv
// Loadable down-counter shared by HOLD length and RUN timeout; saturates at zero.
module cnt16_seq_timer #(
  parameter int unsigned TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_c_o,
  output logic          one_c_o
);

  logic [TW-1:0] value_q;
  logic [TW-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign zero_c_o = (value_q == '0);
  assign one_c_o  = (value_q == TW'(1));

endmodule

// File: rtl/cnt16_seq.sv
// Command sequencer driving the count16 pins (load_l, cnt_in, enable_l, oe_l).
// enable_l is the only combinational output so the counter stops exactly on target.
module cnt16_seq
  import cnt16_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYC = CNT_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  cnt16_seq_if.slave       cmd,
  input  logic [WIDTH-1:0] count_i,
  output logic [WIDTH-1:0] cnt_in_o,
  output logic             load_l_o,
  output logic             enable_l_o,
  output logic             oe_l_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] cnt_in_q, cnt_in_d;
  logic             load_l_q, load_l_d;
  logic             oe_l_q, oe_l_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             at_target;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             tmr_one;

  assign accept    = cmd.cmd_valid && !busy_q;
  assign at_target = (count_i == target_q);

  cnt16_seq_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_c_o   (tmr_zero),
    .one_c_o    (tmr_one)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_in_d = cnt_in_q;
    load_l_d = 1'b1;
    oe_l_d   = oe_l_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_LOAD: begin
              state_d  = ST_LOAD;
              load_l_d = 1'b0;
              cnt_in_d = cmd.cmd_data;
            end
            OP_RUN: begin
              state_d  = ST_RUN;
              target_d = cmd.cmd_data;
              tmr_load = 1'b1;
              tmr_val  = TW'(TIMEOUT_CYC);
            end
            OP_HOLD: begin
              state_d  = ST_HOLD;
              tmr_load = 1'b1;
              tmr_val  = TW'(cmd.cmd_data);
            end
            default: begin
              state_d = ST_FIN;
              oe_l_d  = ~cmd.cmd_data[0];
            end
          endcase
        end
      end
      ST_LOAD: state_d = ST_FIN;
      ST_RUN: begin
        if (at_target) begin
          state_d = ST_FIN;
        end else if (tmr_zero) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      // A zero-length hold still spends one cycle here.
      ST_HOLD: begin
        if (tmr_zero || tmr_one) begin
          state_d = ST_FIN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_FIN);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cnt_in_q <= '0;
      load_l_q <= 1'b1;
      oe_l_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_in_q <= cnt_in_d;
      load_l_q <= load_l_d;
      oe_l_q   <= oe_l_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign enable_l_o    = !((state_q == ST_RUN) && !at_target && !tmr_zero);
  assign cmd.cmd_ready = !busy_q;
  assign cnt_in_o      = cnt_in_q;
  assign load_l_o      = load_l_q;
  assign oe_l_o        = oe_l_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cnt16_seq.sv
// Directed bench for cnt16_seq driving a behavioural count16 with a stuck-count fault hook.
module tb_cnt16_seq;
  import cnt16_seq_pkg::*;

  localparam int unsigned W   = 4;
  localparam int unsigned TMO = 20;

  typedef struct {
    string      tag;
    int         lat;
    logic       err;
    logic [W-1:0] cnt;
    int         en_low;
    int         ld_low;
    logic       oe_l;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] count;
  logic [W-1:0] cnt_in;
  logic         load_l, enable_l, oe_l, busy, done, err;
  logic         stuck;
  logic [W-1:0] cnt_q;

  int n_cmp;
  int n_err;
  exp_t exp_q[$];

  logic [W-1:0] exp_cnt;
  logic         exp_oe;

  cnt16_seq_if #(.WIDTH(W)) cmd_if ();

  cnt16_seq #(.WIDTH(W), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .count_i    (count),
    .cnt_in_o   (cnt_in),
    .load_l_o   (load_l),
    .enable_l_o (enable_l),
    .oe_l_o     (oe_l),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count16 model: load beats enable, wraps naturally; stuck freezes the count.
  always_ff @(posedge clk) begin
    if (rst)                      cnt_q <= '0;
    else if (!load_l)             cnt_q <= cnt_in;
    else if (!enable_l && !stuck) cnt_q <= cnt_q + 4'd1;
  end
  assign count = cnt_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Build the expectation, push it, drive the command, then pop and compare on done.
  task automatic run_cmd(input string tag, input op_e op, input logic [W-1:0] data);
    exp_t e;
    exp_t g;
    int   k;
    int   en_n;
    int   ld_n;
    int   rdy_n;
    int   busy_n;
    logic got;
    e.tag = tag; e.err = 1'b0; e.en_low = 0; e.ld_low = 0;
    case (op)
      OP_LOAD: begin e.lat = 2; e.ld_low = 1; exp_cnt = data; end
      OP_OE:   begin e.lat = 1; exp_oe = ~data[0]; end
      OP_HOLD: e.lat = 1 + ((data == 0) ? 1 : int'(data));
      default: begin
        if (exp_cnt == data) begin
          e.lat = 2;
        end else if (stuck) begin
          e.lat = TMO + 2; e.err = 1'b1; e.en_low = TMO;
        end else begin
          e.en_low = int'(4'(data - exp_cnt));
          e.lat    = e.en_low + 2;
          exp_cnt  = data;
        end
      end
    endcase
    e.cnt  = exp_cnt;
    e.oe_l = exp_oe;
    exp_q.push_back(e);

    @(negedge clk);
    check({tag, ".ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data = '1;

    en_n = 0; ld_n = 0; rdy_n = 0; busy_n = 0; got = 1'b0; k = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (!enable_l) en_n++;
      if (!load_l) ld_n++;
      if (cmd_if.cmd_ready) rdy_n++;
      if (busy) busy_n++;
      if (done) begin
        got = 1'b1;
        k   = c;
      end
    end
    check({tag, ".done_seen"}, 32'(got), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check({g.tag, ".latency"}, 32'(k), 32'(g.lat));
      check({g.tag, ".err"}, 32'(err), 32'(g.err));
      check({g.tag, ".count"}, 32'(count), 32'(g.cnt));
      check({g.tag, ".enable_low"}, 32'(en_n), 32'(g.en_low));
      check({g.tag, ".load_low"}, 32'(ld_n), 32'(g.ld_low));
      check({g.tag, ".oe_l"}, 32'(oe_l), 32'(g.oe_l));
      check({g.tag, ".busy_cycles"}, 32'(busy_n), 32'(g.lat));
      check({g.tag, ".ready_while_busy"}, 32'(rdy_n), 32'd0);
    end
  endtask

  initial begin
    int dn;
    n_cmp = 0; n_err = 0;
    stuck = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = '0;
    exp_cnt = '0;
    exp_oe  = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.load_l",   32'(load_l),   32'd1);
    check("rst.enable_l", 32'(enable_l), 32'd1);
    check("rst.oe_l",     32'(oe_l),     32'd1);
    check("rst.ready",    32'(cmd_if.cmd_ready), 32'd1);
    check("rst.done",     32'(done),     32'd0);
    check("rst.busy",     32'(busy),     32'd0);
    check("rst.err",      32'(err),      32'd0);
    check("rst.cnt_in",   32'(cnt_in),   32'd0);
    rst = 1'b0;

    run_cmd("oe_on",     OP_OE,   4'h1);
    run_cmd("load_a",    OP_LOAD, 4'hA);
    run_cmd("run_wrap",  OP_RUN,  4'h1);
    run_cmd("run_equal", OP_RUN,  4'h1);
    run_cmd("hold3",     OP_HOLD, 4'h3);
    run_cmd("hold0",     OP_HOLD, 4'h0);
    run_cmd("load_5",    OP_LOAD, 4'h5);
    run_cmd("run_full",  OP_RUN,  4'h4);
    run_cmd("hold15",    OP_HOLD, 4'hF);
    run_cmd("oe_off",    OP_OE,   4'h0);
    run_cmd("load_2",    OP_LOAD, 4'h2);

    stuck = 1'b1;
    run_cmd("run_stuck", OP_RUN,  4'h9);
    stuck = 1'b0;
    check("cnt_in_held", 32'(cnt_in), 32'h2);

    // Reset while the counter is mid-run: no done, straight back to idle.
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_RUN;
    cmd_if.cmd_data  = 4'h1;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrun.enable_low", 32'(enable_l), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun.ready",    32'(cmd_if.cmd_ready), 32'd1);
    check("midrun.busy",     32'(busy),     32'd0);
    check("midrun.enable_l", 32'(enable_l), 32'd1);
    check("midrun.oe_l",     32'(oe_l),     32'd1);
    check("midrun.cnt_in",   32'(cnt_in),   32'd0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrun.no_done", 32'(dn), 32'd0);
    exp_cnt = '0;
    exp_oe  = 1'b1;

    run_cmd("load_7_after_rst", OP_LOAD, 4'h7);
    run_cmd("run_after_rst",    OP_RUN,  4'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
